gmii_to_xgmii: RTL and testbench
================================

// Module: gmii_to_xgmii
// PURPOSE
//  Converts a received GMII byte stream into a 64-bit XGMII RX stream for a 10G MAC.
//  Single clock domain: GMII bytes arrive synchronously with a byte-enable strobe,
//  e.g. a 125 MHz rate carried on a 156.25 MHz clock.
//  Each frame is fully buffered (store-and-forward), then replayed at full XGMII
//  width with start, preamble and terminate characters.
// PARAMETERS
//  FRAME_MAX_BIT_WIDTH  11  log2 of frame buffer size in bytes (11:2048 12:4096 13:8192 14:16384)
// PORTS
//  xgmii_clk   in   1   sole clock, rising edge
//  sys_rst     in   1   asynchronous, active-low reset (0 = reset)
//  gmii_en     in   1   byte strobe; gmii_dv/gmii_rxd sampled only when 1
//  gmii_dv     in   1   GMII receive data valid
//  gmii_rxd    in   8   GMII receive byte (includes preamble/SFD)
//  xgmii_rxd   out  64  XGMII data; lane k = bits [8k+7:8k]; lane 0 is the first byte
//  xgmii_rxc   out  8   XGMII control flags; bit k=1 marks lane k as a control char
// BEHAVIOUR
//  Reset: xgmii_rxd=64'h0707070707070707, xgmii_rxc=8'hFF (idle). All buffers empty.
//  Input FSM (advances only on gmii_en=1):
//   IDLE   -> PRE on dv=1.
//   PRE    discards bytes until 8'hD5 (SFD), then -> DATA.
//          dv=0 before SFD: -> IDLE, nothing stored.
//   DATA   dv=1: write byte at wr_ptr+len; len++.
//          dv=0: commit frame if len>0 (push len to length FIFO, advance wr_ptr); -> IDLE.
//   DROP   entered when a byte would overflow free space (2^N - used).
//          Also entered when len would exceed 2^N-1 or the length FIFO (depth 4) is full.
//          Discards bytes until dv=0, then -> IDLE with no commit.
//  Storage: 2^N bytes, organised as 2^(N-3) 64-bit words; writes are byte-lane enabled.
//   Pointers wrap modulo 2^N.
//   Each frame starts on an 8-byte-aligned address; wr_ptr rounds up on commit.
//  Output FSM (every clock):
//   OIDLE  drive idle (07 x8, rxc FF).
//          If the length FIFO is non-empty and one idle word has followed the last
//          terminate -> START.
//   START  one cycle: rxd=64'hD5555555555555FB, rxc=8'h01.
//   DATA   one word per cycle, rxc=0 for full words.
//          Last word with r=len%8 valid bytes (r!=0): lanes 0..r-1 data, lane r=FD,
//          lanes above r=07; rxc=~((1<<r)-1)&8'hFF. Then -> OIDLE.
//          If r==0: after the last full word emit one word FD,07x7 (rxc FF), then -> OIDLE.
//   Frame release: rd_ptr advances by ceil(len/8)*8. Length FIFO pops at START.
//  Minimum gap of one idle word between frames; back-to-back frames queue (max 4).
//  Latency: first START = 2 clocks after the commit edge (FSM handoff, then the idle word).
//  Simultaneous commit and release of the same storage: write and read pointers are
//   independent, so no stall.
//  Free space is computed from rd_ptr at the start of the cycle.
//  Reset mid-frame: any partial output frame is abandoned; output goes idle immediately.
// TESTING
//  1. Reset held 2 clocks -> rxd=0707070707070707, rxc=FF throughout and after release.
//  2. Preamble 55x7, D5, 64 bytes 00..3F, dv low (gmii_en every clock):
//     -> START word; 8 words 0706050403020100..3F3E3D3C3B3A3938 with rxc=00;
//     -> then FD07..07 with rxc=FF; then idle.
//  3. 60-byte frame -> 7 full words; last word lanes0-3 = 38..3B, lane4=FD,
//     lanes5-7=07, rxc=F0.
//  4. gmii_en toggling every 5th clock off; 2 frames separated by 12 GMII idle bytes
//     -> both frames emitted intact, each with its own START, >=1 idle word between.
//  5. N=11, 2100-byte frame -> dropped, no START.
//     A following 64-byte frame -> emitted correctly.
//  6. dv pulse of 55 55 with no SFD -> no output. Reset asserted during output DATA
//     -> outputs idle within the same cycle (async), buffers empty.

Source files
------------

// File: rtl/gmii_to_xgmii_if.sv
// GMII receive byte stream in, 64-bit XGMII receive stream out.
// Master drives GMII and observes XGMII; the converter is the slave.
interface gmii_to_xgmii_if;
    logic        gmii_en;
    logic        gmii_dv;
    logic [7:0]  gmii_rxd;
    logic [63:0] xgmii_rxd;
    logic [7:0]  xgmii_rxc;

    modport master (
        output gmii_en, gmii_dv, gmii_rxd,
        input  xgmii_rxd, xgmii_rxc
    );

    modport slave (
        input  gmii_en, gmii_dv, gmii_rxd,
        output xgmii_rxd, xgmii_rxc
    );
endinterface

// File: rtl/gmii_to_xgmii.sv
// Store-and-forward GMII to XGMII RX converter.
// Frames are buffered whole, then replayed at 64 bits per clock.
module gmii_to_xgmii #(
    parameter int FRAME_MAX_BIT_WIDTH = 11
) (
    input logic             xgmii_clk,
    input logic             sys_rst,
    gmii_to_xgmii_if.slave  bus
);
    localparam int N     = FRAME_MAX_BIT_WIDTH;
    localparam int W     = N - 3;
    localparam int WORDS = 1 << W;

    localparam logic [63:0] IDLE_D  = 64'h0707070707070707;
    localparam logic [63:0] START_D = 64'hD5555555555555FB;
    localparam logic [63:0] TERM_D  = 64'h07070707070707FD;
    localparam logic [N:0]  CAP     = {1'b1, {N{1'b0}}};
    localparam logic [N:0]  ALIGN   = {{(N-2){1'b1}}, 3'b000};

    typedef enum logic [1:0] {I_IDLE, I_PRE, I_DATA, I_DROP} in_t;
    typedef enum logic [1:0] {O_IDLE, O_START, O_DATA, O_TERM} out_t;

    logic [63:0]  mem [WORDS];

    in_t          in_q, in_d;
    logic [N:0]   wr_ptr;
    logic [N-1:0] len;
    logic [N-1:0] wr_addr;
    logic [N:0]   used, free, len_up;
    logic         wr_en, commit, len_inc, len_clr;

    logic [N-1:0] ff_len [4];
    logic [2:0]   ff_wp, ff_rp;
    logic         ff_full, ff_empty;

    out_t         out_q, out_d;
    logic [N:0]   rd_ptr, rel_up;
    logic [N-1:0] cur_len, rem;
    logic [W-1:0] cnt;
    logic [63:0]  rd_word, rxd_d;
    logic [7:0]   rxc_d;
    logic         pop, cnt_inc, release_fr;

    assign used     = wr_ptr - rd_ptr;
    assign free     = CAP - used;
    assign wr_addr  = wr_ptr[N-1:0] + len;
    assign len_up   = ({1'b0, len} + (N+1)'(7)) & ALIGN;
    assign ff_full  = (ff_wp - ff_rp) == 3'd4;
    assign ff_empty = ff_wp == ff_rp;

    // Input side: strip preamble, write payload, commit or drop
    always_comb begin
        in_d    = in_q;
        wr_en   = 1'b0;
        commit  = 1'b0;
        len_inc = 1'b0;
        len_clr = 1'b0;
        if (bus.gmii_en) begin
            unique case (in_q)
                I_IDLE: begin
                    len_clr = 1'b1;
                    if (bus.gmii_dv) in_d = I_PRE;
                end
                I_PRE: begin
                    if (!bus.gmii_dv)              in_d = I_IDLE;
                    else if (bus.gmii_rxd == 8'hD5) in_d = I_DATA;
                end
                I_DATA: begin
                    if (!bus.gmii_dv) begin
                        commit  = len != '0;
                        len_clr = 1'b1;
                        in_d    = I_IDLE;
                    end else if (({1'b0, len} >= free) ||
                                 (&len) || ff_full) begin
                        len_clr = 1'b1;
                        in_d    = I_DROP;
                    end else begin
                        wr_en   = 1'b1;
                        len_inc = 1'b1;
                    end
                end
                I_DROP: begin
                    if (!bus.gmii_dv) in_d = I_IDLE;
                end
                default: in_d = I_IDLE;
            endcase
        end
    end

    always_ff @(posedge xgmii_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            in_q   <= I_IDLE;
            len    <= '0;
            wr_ptr <= '0;
            ff_wp  <= '0;
        end else begin
            in_q <= in_d;
            if (len_clr)      len <= '0;
            else if (len_inc) len <= len + 1'b1;
            if (commit) begin
                wr_ptr <= wr_ptr + len_up;
                ff_wp  <= ff_wp + 3'd1;
            end
        end
    end

    always_ff @(posedge xgmii_clk) begin
        if (wr_en)
            mem[wr_addr[N-1:3]][{wr_addr[2:0], 3'b000} +: 8] <= bus.gmii_rxd;
        if (commit)
            ff_len[ff_wp[1:0]] <= len;
    end

    assign rd_word = mem[rd_ptr[N-1:3] + cnt];
    assign rem     = cur_len - {cnt, 3'b000};
    assign rel_up  = ({1'b0, cur_len} + (N+1)'(7)) & ALIGN;

    // Output side: OIDLE always emits one idle word before START
    always_comb begin
        out_d      = out_q;
        rxd_d      = IDLE_D;
        rxc_d      = 8'hFF;
        pop        = 1'b0;
        cnt_inc    = 1'b0;
        release_fr = 1'b0;
        unique case (out_q)
            O_IDLE: begin
                if (!ff_empty) out_d = O_START;
            end
            O_START: begin
                rxd_d = START_D;
                rxc_d = 8'h01;
                pop   = 1'b1;
                out_d = O_DATA;
            end
            O_DATA: begin
                if (rem > N'(8)) begin
                    rxd_d   = rd_word;
                    rxc_d   = 8'h00;
                    cnt_inc = 1'b1;
                end else if (rem == N'(8)) begin
                    rxd_d = rd_word;
                    rxc_d = 8'h00;
                    out_d = O_TERM;
                end else begin
                    for (int k = 0; k < 8; k++) begin
                        if (k < int'(rem[2:0])) begin
                            rxd_d[8*k +: 8] = rd_word[8*k +: 8];
                            rxc_d[k]        = 1'b0;
                        end else if (k == int'(rem[2:0])) begin
                            rxd_d[8*k +: 8] = 8'hFD;
                        end
                    end
                    release_fr = 1'b1;
                    out_d      = O_IDLE;
                end
            end
            O_TERM: begin
                rxd_d      = TERM_D;
                release_fr = 1'b1;
                out_d      = O_IDLE;
            end
            default: out_d = O_IDLE;
        endcase
    end

    always_ff @(posedge xgmii_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            out_q         <= O_IDLE;
            bus.xgmii_rxd <= IDLE_D;
            bus.xgmii_rxc <= 8'hFF;
            rd_ptr        <= '0;
            ff_rp         <= '0;
            cnt           <= '0;
            cur_len       <= '0;
        end else begin
            out_q         <= out_d;
            bus.xgmii_rxd <= rxd_d;
            bus.xgmii_rxc <= rxc_d;
            if (pop) begin
                ff_rp   <= ff_rp + 3'd1;
                cur_len <= ff_len[ff_rp[1:0]];
                cnt     <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
            if (release_fr) rd_ptr <= rd_ptr + rel_up;
        end
    end
endmodule

// File: tb/tb_gmii_to_xgmii.sv
// Directed bench for gmii_to_xgmii: reset, framing, gaps,
// oversize drop, runt preamble and async reset mid-frame.
module tb_gmii_to_xgmii;
    localparam logic [71:0] IDLE_W  = {8'hFF, 64'h0707070707070707};
    localparam logic [71:0] START_W = {8'h01, 64'hD5555555555555FB};
    localparam logic [71:0] TERM_W  = {8'hFF, 64'h07070707070707FD};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gmii_to_xgmii_if ifc ();

    gmii_to_xgmii #(.FRAME_MAX_BIT_WIDTH(11)) dut (
        .xgmii_clk (clk),
        .sys_rst   (rst_n),
        .bus       (ifc)
    );

    int          tests    = 0;
    int          fails    = 0;
    int          gap_err  = 0;
    int          cyc      = 0;
    bit          gap_mode = 1'b0;
    bit          prev_idle = 1'b1;
    logic [71:0] mon_w;
    logic [71:0] obs_q [$];

    // Record every non-idle word; a START must follow an idle word
    always @(negedge clk) begin
        mon_w = {ifc.xgmii_rxc, ifc.xgmii_rxd};
        if (rst_n) begin
            if (mon_w != IDLE_W) begin
                if (mon_w == START_W && !prev_idle) gap_err++;
                obs_q.push_back(mon_w);
            end
            prev_idle = (mon_w == IDLE_W);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [71:0] obs,
                       input logic [71:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic dv, input logic [7:0] d);
        bit done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (gap_mode && (cyc % 5 == 4)) begin
                ifc.gmii_en = 1'b0;
            end else begin
                ifc.gmii_en  = 1'b1;
                ifc.gmii_dv  = dv;
                ifc.gmii_rxd = d;
                done = 1'b1;
            end
            cyc++;
        end
    endtask

    task automatic send_frame(input int len, input logic [7:0] base,
                              input int tail);
        for (int i = 0; i < 7; i++) put(1'b1, 8'h55);
        put(1'b1, 8'hD5);
        for (int i = 0; i < len; i++) put(1'b1, 8'(base + i));
        for (int i = 0; i < tail; i++) put(1'b0, 8'h00);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input int len,
                               input logic [7:0] base);
        logic [71:0] exp_q [$];
        logic [71:0] w;
        int full = len / 8;
        int r    = len % 8;
        exp_q.push_back(START_W);
        for (int i = 0; i < full; i++) begin
            w = '0;
            for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'(base + 8*i + k);
            exp_q.push_back(w);
        end
        if (r == 0) begin
            exp_q.push_back(TERM_W);
        end else begin
            w = IDLE_W;
            for (int k = 0; k < 8; k++) begin
                if (k < r) begin
                    w[8*k +: 8] = 8'(base + 8*full + k);
                    w[64 + k]   = 1'b0;
                end else if (k == r) begin
                    w[8*k +: 8] = 8'hFD;
                end
            end
            exp_q.push_back(w);
        end
        foreach (exp_q[i]) begin
            if (obs_q.size() == 0) w = 'x;
            else                   w = obs_q.pop_front();
            chk($sformatf("%s_w%0d", tag, i), w, exp_q[i]);
        end
    endtask

    bit found;
    int budget;

    initial begin
        ifc.gmii_en  = 1'b1;
        ifc.gmii_dv  = 1'b0;
        ifc.gmii_rxd = 8'h00;

        // 1: reset held two clocks
        repeat (2) begin
            @(negedge clk);
            chk("rst_idle", {ifc.xgmii_rxc, ifc.xgmii_rxd}, IDLE_W);
        end
        rst_n = 1'b1;
        wait_clk(2);
        chk("post_rst_idle", {ifc.xgmii_rxc, ifc.xgmii_rxd}, IDLE_W);

        // 2: 64-byte frame, r == 0 needs a separate terminate word
        send_frame(64, 8'h00, 12);
        wait_clk(30);
        chk("t2_size", 72'(obs_q.size()), 72'd10);
        chk("t2_first", obs_q[1], {8'h00, 64'h0706050403020100});
        chk("t2_last", obs_q[8], {8'h00, 64'h3F3E3D3C3B3A3938});
        chk("t2_term", obs_q[9], TERM_W);
        check_frame("t2", 64, 8'h00);

        // 3: 60-byte frame, terminate inside last word
        send_frame(60, 8'h00, 12);
        wait_clk(30);
        chk("t3_size", 72'(obs_q.size()), 72'd9);
        chk("t3_tail", obs_q[8], {8'hF0, 64'h070707FD3B3A3938});
        check_frame("t3", 60, 8'h00);

        // 4: byte strobe gaps, two frames
        gap_err  = 0;
        gap_mode = 1'b1;
        send_frame(20, 8'h40, 12);
        send_frame(13, 8'h80, 12);
        wait_clk(40);
        gap_mode = 1'b0;
        check_frame("t4a", 20, 8'h40);
        check_frame("t4b", 13, 8'h80);
        chk("t4_gap", 72'(gap_err), 72'd0);
        chk("t4_extra", 72'(obs_q.size()), 72'd0);

        // 5: oversize frame dropped, next frame intact
        send_frame(2100, 8'h00, 12);
        wait_clk(30);
        chk("t5_drop", 72'(obs_q.size()), 72'd0);
        send_frame(64, 8'h10, 12);
        wait_clk(30);
        check_frame("t5", 64, 8'h10);
        chk("t5_extra", 72'(obs_q.size()), 72'd0);

        // 6a: preamble with no SFD
        put(1'b1, 8'h55);
        put(1'b1, 8'h55);
        for (int i = 0; i < 4; i++) put(1'b0, 8'h00);
        wait_clk(20);
        chk("t6_runt", 72'(obs_q.size()), 72'd0);

        // 6b: async reset while output is in DATA
        send_frame(64, 8'h20, 1);
        found  = 1'b0;
        budget = 0;
        while (!found && budget < 20) begin
            @(negedge clk);
            if ({ifc.xgmii_rxc, ifc.xgmii_rxd} == START_W) found = 1'b1;
            budget++;
        end
        chk("t6_start_seen", 72'(found), 72'd1);
        wait_clk(2);
        chk("t6_in_data", 72'(ifc.xgmii_rxc), 72'h00);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_idle", {ifc.xgmii_rxc, ifc.xgmii_rxd}, IDLE_W);
        wait_clk(2);
        rst_n = 1'b1;
        obs_q.delete();
        wait_clk(30);
        chk("t6_empty", 72'(obs_q.size()), 72'd0);
        chk("t6_final_idle", {ifc.xgmii_rxc, ifc.xgmii_rxd}, IDLE_W);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
